txn_initiator: RTL and testbench
================================

# txn_initiator

Synthesizable bus initiator for the fabric transaction port (`txn_req`/`txn_wr`/`txn_raddr`/`txn_waddr`/`txn_wdata`/`txn_rdata`/`txn_rdy`). It executes one command at a time: a burst of word reads or word writes at consecutive word addresses, issuing one transaction per word with the edge-triggered req/rdy handshake. It sits between fabric load/store logic and the memory responder, and replaces ad-hoc handshake code with one checked engine.

## Interface
- `LEN_W`, 8: width of the command word count.
- `ACK_TIMEOUT`, 16: maximum cycles in ISSUE waiting for `txn_rdy` low before aborting.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command strobe, accepted when `cmd_ready`=1.
- `cmd_ready` out 1: idle and `txn_rdy`=1.
- `cmd_wr` in 1: 1=write burst, 0=read burst.
- `cmd_addr` in 32: byte base address, word aligned.
- `cmd_len` in LEN_W: number of words.
- `wr_data` in 32, `wr_valid` in 1, `wr_ready` out 1: write-word stream, transfer on valid&ready.
- `rd_data` out 32, `rd_valid` out 1: read-word stream, one-cycle pulse, no backpressure.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse at command end.
- `err` out 1: sticky timeout flag, cleared on next accepted command.
- `txn_req`, `txn_wr` out 1; `txn_raddr`, `txn_waddr`, `txn_wdata` out 32; `txn_rdata` in 32; `txn_rdy` in 1.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE: `cmd_ready`=`txn_rdy`. On accept, latch addr/len/dir and clear `err`. len=0 goes to DONE. Otherwise go to FETCH for writes and ISSUE for reads.
- FETCH: `wr_ready`=1. On `wr_valid`, latch `wr_data` into `txn_wdata` and go to ISSUE.
- ISSUE: `txn_req`=1. `txn_wr`=1 only for writes; it rises in the same cycle as `txn_req`. For reads, `txn_raddr`=current address and `txn_waddr`=0. For writes, `txn_waddr`=current address and `txn_raddr`=0. Address and data are held stable for the whole state.
  - `txn_rdy`=0 (ack): go to WAIT.
  - Watchdog reaches ACK_TIMEOUT with `txn_rdy` still 1: set `err` and go to DONE, skipping the remaining words.
- WAIT: `txn_req`=`txn_wr`=0. On `txn_rdy`=1:
  - Read: `rd_data`=`txn_rdata` and `rd_valid`=1 in the following cycle.
  - Then decrement the count and add 4 to the address (mod 2^32, wraps silently).
  - count becomes 0: go to DONE. Otherwise go to FETCH for writes and ISSUE for reads.
- DONE: `done`=1 for one cycle, then IDLE.
- `cmd_valid` while busy is ignored and not queued.
- Reset mid-burst: all outputs return to reset values immediately and the remaining words are discarded. Because `cmd_ready` requires `txn_rdy`, no new command starts until the responder finishes any orphaned transaction.

## Timing
- Reset values: `txn_req`, `txn_wr`, `rd_valid`, `done`, `busy`, `err`, `wr_ready` = 0; all address and data outputs = 0; state = IDLE.
- `cmd_ready` is 1 after reset once `txn_rdy`=1.
- All outputs are registered, except `cmd_ready` and `wr_ready`, which are decoded from state.
- Every `txn_req` rising edge is preceded by at least one low cycle, because WAIT always lasts at least one cycle.
- The responder registers `req` and the addresses together, so the address is valid from the first `txn_req`-high cycle.
- Per-word cost with a responder of latency L (rdy low→high): 1 (ISSUE) + ack delay (≈3) + L + 1 cycles. Writes add at least 1 FETCH cycle.
- `rd_valid` occurs exactly once per read word, in address order.
- `done` follows the last word's `txn_rdy` rise by 2 cycles.
- Watchdog counts ISSUE cycles from 1. Abort happens in the cycle the count equals ACK_TIMEOUT.

## Structure
- Shared fabric package holds:
  - the state enum;
  - `TXN_WORD_BYTES`=4;
  - base constants `RD_BASE`=32'h4000_0000 and `WR_BASE`=32'h4000_1000, used by callers.
- One natural sub-module: `txn_watchdog`, a saturating counter with clear and enable that outputs an expiry flag.
- Target size: ~200 lines.

## Test plan
- Read burst, addr=32'h4000_0000, len=4, responder latency 16 (memory preloaded 1,2,3,4) -> `rd_valid` 4 times with data 1..4; `txn_raddr` 0x4000_0000..0x4000_000C; one `done`; `err`=0.
- Write burst, addr=32'h4000_1000, len=3, `wr_valid` held high with data A,B,C -> memory words 0..2 = A,B,C; `txn_wr` high only while `txn_req` high; `done` once.
- len=0 -> no `txn_req` edge; `done` 2 cycles after accept.
- Responder that never drops `txn_rdy`, len=2 -> `txn_req` high for exactly 16 cycles; `err`=1; `done` pulse; second word never issued.
- Reset asserted 5 cycles into WAIT, then released -> outputs are 0 next cycle; `cmd_ready` stays 0 until the responder raises `txn_rdy`; the next command completes correctly.
- Address 32'hFFFF_FFFC, read len=2 -> second `txn_raddr`=0.

Source files
------------

// File: rtl/txn_initiator_pkg.sv
// Shared fabric definitions for the transaction initiator: FSM states,
// word geometry and the base addresses callers use for read/write windows.
package txn_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } txn_state_e;

  localparam int unsigned TXN_WORD_BYTES = 4;

  localparam logic [31:0] RD_BASE = 32'h4000_0000;
  localparam logic [31:0] WR_BASE = 32'h4000_1000;

  // Consecutive word address; wraps modulo 2^32 without any flag.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'(TXN_WORD_BYTES);
  endfunction

endpackage

// File: rtl/txn_initiator_if.sv
// Fabric transaction port: edge-triggered req/rdy handshake with separate
// read/write address buses and a write-data bus.
interface txn_initiator_if;

  logic        txn_req;
  logic        txn_wr;
  logic [31:0] txn_raddr;
  logic [31:0] txn_waddr;
  logic [31:0] txn_wdata;
  logic [31:0] txn_rdata;
  logic        txn_rdy;

  modport master (
    output txn_req, txn_wr, txn_raddr, txn_waddr, txn_wdata,
    input  txn_rdata, txn_rdy
  );

  modport slave (
    input  txn_req, txn_wr, txn_raddr, txn_waddr, txn_wdata,
    output txn_rdata, txn_rdy
  );

endinterface

// File: rtl/txn_watchdog.sv
// Saturating cycle counter with clear/enable; expired is raised in the
// LIMIT-th enabled cycle counted from 1.
module txn_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt holds the number of earlier enabled cycles, so the current one is cnt+1.
  assign expired = en && (cnt >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/txn_initiator.sv
// Burst bus initiator: executes one read or write burst command at a time,
// one req/rdy transaction per word at consecutive word addresses.
module txn_initiator
  import txn_initiator_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [31:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,

  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,

  output logic [31:0]       rd_data,
  output logic              rd_valid,

  output logic              busy,
  output logic              done,
  output logic              err,

  txn_initiator_if.master   txn
);

  txn_state_e state, state_nxt;

  logic [31:0]      addr_r, addr_nxt;
  logic [LEN_W-1:0] len_r, len_nxt;
  logic             wr_r, wr_nxt;

  logic accept;
  logic word_done;
  logic wd_expired;
  logic issue_nxt;

  logic        req_q;
  logic        txn_wr_q;
  logic [31:0] raddr_q;
  logic [31:0] waddr_q;
  logic [31:0] wdata_q;

  assign cmd_ready = (state == ST_IDLE) && txn.txn_rdy;
  assign wr_ready  = (state == ST_FETCH);
  assign accept    = cmd_valid && cmd_ready;
  assign word_done = (state == ST_WAIT) && txn.txn_rdy;
  assign issue_nxt = (state_nxt == ST_ISSUE);

  txn_watchdog #(
    .LIMIT (ACK_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_ISSUE),
    .en      (state == ST_ISSUE),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst context is only meaningful after an accept, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_r <= addr_nxt;
    len_r  <= len_nxt;
    wr_r   <= wr_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_r;
    len_nxt   = len_r;
    wr_nxt    = wr_r;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          addr_nxt = cmd_addr;
          len_nxt  = cmd_len;
          wr_nxt   = cmd_wr;
          if (cmd_len == '0) begin
            state_nxt = ST_DONE;
          end else if (cmd_wr) begin
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_FETCH: begin
        if (wr_valid) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!txn.txn_rdy) begin
          state_nxt = ST_WAIT;
        end else if (wd_expired) begin
          state_nxt = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (txn.txn_rdy) begin
          addr_nxt = next_word_addr(addr_r);
          len_nxt  = len_r - LEN_W'(1);
          if (len_r == LEN_W'(1)) begin
            state_nxt = ST_DONE;
          end else if (wr_r) begin
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are registered from the next state so req, dir and address
  // appear together in the first ISSUE cycle and hold for the whole state.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= 1'b0;
      txn_wr_q <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      req_q    <= issue_nxt;
      txn_wr_q <= issue_nxt && wr_nxt;
      raddr_q  <= (issue_nxt && !wr_nxt) ? addr_nxt : '0;
      waddr_q  <= (issue_nxt &&  wr_nxt) ? addr_nxt : '0;
      if ((state == ST_FETCH) && wr_valid) begin
        wdata_q <= wr_data;
      end
      rd_valid <= word_done && !wr_r;
      if (word_done && !wr_r) begin
        rd_data <= txn.txn_rdata;
      end
      busy <= (state_nxt != ST_IDLE);
      done <= (state == ST_DONE);
      if (accept) begin
        err <= 1'b0;
      end else if ((state == ST_ISSUE) && txn.txn_rdy && wd_expired) begin
        err <= 1'b1;
      end
    end
  end

  assign txn.txn_req   = req_q;
  assign txn.txn_wr    = txn_wr_q;
  assign txn.txn_raddr = raddr_q;
  assign txn.txn_waddr = waddr_q;
  assign txn.txn_wdata = wdata_q;

endmodule

// File: tb/tb_txn_initiator.sv
// Bench for txn_initiator: behavioural responder, passive monitor and
// per-scenario tasks comparing against bench-computed expectations.
module tb_txn_initiator;
  import txn_initiator_pkg::*;

  localparam int LEN_W       = 8;
  localparam int ACK_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_wr = 1'b0;
  logic [31:0]      cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0]      wr_data;
  logic             wr_valid = 1'b0;
  logic             cmd_ready, wr_ready, rd_valid, busy, done, err;
  logic [31:0]      rd_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  txn_initiator_if bus ();

  txn_initiator #(
    .LEN_W       (LEN_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .txn       (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int midx(input logic [31:0] a);
    return int'(a[12:2]);
  endfunction

  function automatic logic [31:0] rom(input logic [31:0] a);
    return ((a - RD_BASE) >> 2) + 32'd1;
  endfunction

  // Responder: reads come from rom(), writes land in mem.
  int          cfg_ack = 2;
  int          cfg_lat = 3;
  bit          cfg_never = 1'b0;
  logic        rsp_rdy = 1'b1;
  logic [31:0] rsp_rdata = '0;
  int          rsp_phase = 0;
  int          rsp_cnt = 0;
  logic        req_d = 1'b0;
  logic        lat_wr = 1'b0;
  logic [31:0] lat_addr = '0;
  logic [31:0] lat_wdata = '0;
  int          rise_cyc = 0;
  logic [31:0] mem [0:2047];

  assign bus.txn_rdy   = rsp_rdy;
  assign bus.txn_rdata = rsp_rdata;

  always @(posedge clk) begin
    req_d <= bus.txn_req;
    case (rsp_phase)
      0: if (bus.txn_req && !req_d && !cfg_never) begin
        lat_wr    <= bus.txn_wr;
        lat_addr  <= bus.txn_wr ? bus.txn_waddr : bus.txn_raddr;
        lat_wdata <= bus.txn_wdata;
        rsp_cnt   <= cfg_ack;
        rsp_phase <= 1;
      end
      1: if (rsp_cnt == 0) begin
        rsp_rdy   <= 1'b0;
        rsp_cnt   <= cfg_lat;
        rsp_phase <= 2;
      end else rsp_cnt <= rsp_cnt - 1;
      2: if (rsp_cnt == 0) begin
        rsp_rdy  <= 1'b1;
        rise_cyc <= cyc + 1;
        if (lat_wr) mem[midx(lat_addr)] <= lat_wdata;
        else rsp_rdata <= rom(lat_addr);
        rsp_phase <= 0;
      end else rsp_cnt <= rsp_cnt - 1;
      default: rsp_phase <= 0;
    endcase
  end

  // Write-word source: advances one table entry per accepted transfer.
  logic        wr_clr = 1'b0;
  int          wr_idx = 0;
  logic [31:0] wr_tab [0:2] = '{32'hA5A5_000A, 32'h5A5A_000B, 32'hC3C3_000C};
  always @(posedge clk) begin
    if (wr_clr) wr_idx <= 0;
    else if (wr_valid && wr_ready && wr_idx < 2) wr_idx <= wr_idx + 1;
  end
  assign wr_data = wr_tab[wr_idx];

  // Passive monitor: records what the DUT produces for the tasks to compare.
  int          done_cnt = 0, done_cyc = 0, edge_cnt = 0, req_hi_cnt = 0;
  int          wr_bad = 0, addr_unstable = 0, last_rd_cyc = 0;
  logic        mon_req_prev = 1'b0;
  logic [63:0] mon_addr_prev = '0;
  logic [31:0] obs_rd [$];
  logic [63:0] obs_addr [$];

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (rd_valid === 1'b1) begin
      obs_rd.push_back(rd_data);
      last_rd_cyc = cyc;
    end
    if (bus.txn_req === 1'b1) req_hi_cnt = req_hi_cnt + 1;
    if (bus.txn_req === 1'b1 && mon_req_prev !== 1'b1) begin
      edge_cnt = edge_cnt + 1;
      obs_addr.push_back({bus.txn_raddr, bus.txn_waddr});
    end
    if (bus.txn_req === 1'b1 && mon_req_prev === 1'b1 &&
        {bus.txn_raddr, bus.txn_waddr} !== mon_addr_prev)
      addr_unstable = addr_unstable + 1;
    if (bus.txn_wr === 1'b1 && bus.txn_req !== 1'b1) wr_bad = wr_bad + 1;
    mon_req_prev  = bus.txn_req;
    mon_addr_prev = {bus.txn_raddr, bus.txn_waddr};
  end

  task automatic issue_cmd(input logic wr, input logic [31:0] addr,
                           input logic [LEN_W-1:0] len, output bit ok, output int acc);
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_valid = 1'b1;
      acc       = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.txn_req, bus.txn_wr, rd_valid, done, busy, err, wr_ready} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.txn_req, bus.txn_wr, rd_valid, done, busy, err, wr_ready});
    end
    checks++;
    if ({bus.txn_raddr, bus.txn_waddr, bus.txn_wdata, rd_data} !== 128'b0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {bus.txn_raddr, bus.txn_waddr, bus.txn_wdata, rd_data});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_rd [$];
    logic [63:0] exp_a [$];
    logic [31:0] e;
    logic [63:0] ea;
    bit ok;
    int acc, d0, e0, rb, ab, au0;
    cfg_never = 1'b0; cfg_ack = 2; cfg_lat = 15;
    d0 = done_cnt; e0 = edge_cnt; rb = obs_rd.size(); ab = obs_addr.size(); au0 = addr_unstable;
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(rom(RD_BASE + 32'(4 * i)));
      exp_a.push_back({RD_BASE + 32'(4 * i), 32'h0});
    end
    issue_cmd(1'b0, RD_BASE, 8'd4, ok, acc);
    checks++;
    if (!ok) begin failures++; $display("FAIL rd_accept got=0 exp=1"); end
    for (int i = 0; i < 600 && done_cnt == d0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL rd_done_count got=%0d exp=1", done_cnt - d0); end
    for (int i = 0; exp_rd.size() > 0; i++) begin
      e = exp_rd.pop_front();
      checks++;
      if (rb + i >= obs_rd.size()) begin
        failures++; $display("FAIL rd_data[%0d] got=none exp=%h", i, e);
      end else if (obs_rd[rb + i] !== e) begin
        failures++; $display("FAIL rd_data[%0d] got=%h exp=%h", i, obs_rd[rb + i], e);
      end
    end
    for (int i = 0; exp_a.size() > 0; i++) begin
      ea = exp_a.pop_front();
      checks++;
      if (ab + i >= obs_addr.size()) begin
        failures++; $display("FAIL rd_addr[%0d] got=none exp=%h", i, ea);
      end else if (obs_addr[ab + i] !== ea) begin
        failures++; $display("FAIL rd_addr[%0d] got=%h exp=%h", i, obs_addr[ab + i], ea);
      end
    end
    checks++;
    if (obs_rd.size() - rb != 4 || edge_cnt - e0 != 4) begin
      failures++; $display("FAIL rd_counts got=%0d/%0d exp=4/4", obs_rd.size() - rb, edge_cnt - e0);
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", err); end
    checks++;
    if (done_cyc - rise_cyc != 2) begin failures++; $display("FAIL rd_done_lag got=%0d exp=2", done_cyc - rise_cyc); end
    checks++;
    if (last_rd_cyc - rise_cyc != 1) begin failures++; $display("FAIL rd_valid_lag got=%0d exp=1", last_rd_cyc - rise_cyc); end
    checks++;
    if (addr_unstable != au0) begin failures++; $display("FAIL rd_addr_stable got=%0d exp=0", addr_unstable - au0); end
  endtask

  task automatic test_write_burst();
    logic [63:0] exp_a [$];
    logic [63:0] ea;
    bit ok;
    int acc, d0, e0, ab, wb0;
    cfg_never = 1'b0; cfg_ack = 1; cfg_lat = 3;
    d0 = done_cnt; e0 = edge_cnt; ab = obs_addr.size(); wb0 = wr_bad;
    for (int i = 0; i < 3; i++) exp_a.push_back({32'h0, WR_BASE + 32'(4 * i)});
    wr_clr = 1'b1;
    @(negedge clk);
    wr_clr = 1'b0;
    wr_valid = 1'b1;
    issue_cmd(1'b1, WR_BASE, 8'd3, ok, acc);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
    wr_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL wr_done_count got=%0d exp=1", done_cnt - d0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[midx(WR_BASE + 32'(4 * i))] !== wr_tab[i]) begin
        failures++;
        $display("FAIL wr_mem[%0d] got=%h exp=%h", i, mem[midx(WR_BASE + 32'(4 * i))], wr_tab[i]);
      end
    end
    for (int i = 0; exp_a.size() > 0; i++) begin
      ea = exp_a.pop_front();
      checks++;
      if (ab + i >= obs_addr.size()) begin
        failures++; $display("FAIL wr_addr[%0d] got=none exp=%h", i, ea);
      end else if (obs_addr[ab + i] !== ea) begin
        failures++; $display("FAIL wr_addr[%0d] got=%h exp=%h", i, obs_addr[ab + i], ea);
      end
    end
    checks++;
    if (wr_bad != wb0 || edge_cnt - e0 != 3) begin
      failures++; $display("FAIL wr_dir_edges got=%0d/%0d exp=0/3", wr_bad - wb0, edge_cnt - e0);
    end
  endtask

  task automatic test_len0();
    bit ok;
    int acc, d0, e0;
    d0 = done_cnt; e0 = edge_cnt;
    issue_cmd(1'b0, RD_BASE, 8'd0, ok, acc);
    for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || done_cyc - acc != 2) begin
      failures++; $display("FAIL len0_done got=%0d@%0d exp=1@2", done_cnt - d0, done_cyc - acc);
    end
    checks++;
    if (edge_cnt != e0) begin failures++; $display("FAIL len0_edges got=%0d exp=0", edge_cnt - e0); end
  endtask

  task automatic test_timeout();
    bit ok;
    int acc, d0, e0, h0, ab;
    cfg_never = 1'b1;
    d0 = done_cnt; e0 = edge_cnt; h0 = req_hi_cnt; ab = obs_addr.size();
    issue_cmd(1'b0, RD_BASE + 32'h20, 8'd2, ok, acc);
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (req_hi_cnt - h0 != ACK_TIMEOUT) begin
      failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", req_hi_cnt - h0, ACK_TIMEOUT);
    end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err); end
    checks++;
    if (done_cnt - d0 != 1 || edge_cnt - e0 != 1) begin
      failures++; $display("FAIL to_done_edges got=%0d/%0d exp=1/1", done_cnt - d0, edge_cnt - e0);
    end
    checks++;
    if (obs_addr.size() <= ab || obs_addr[ab] !== {RD_BASE + 32'h20, 32'h0}) begin
      failures++; $display("FAIL to_addr got=%0d entries exp=%h", obs_addr.size() - ab, {RD_BASE + 32'h20, 32'h0});
    end
    cfg_never = 1'b0;
    d0 = done_cnt;
    issue_cmd(1'b0, RD_BASE, 8'd0, ok, acc);
    for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    int acc, d0, rb;
    cfg_never = 1'b0; cfg_ack = 2; cfg_lat = 29;
    rb = obs_rd.size();
    issue_cmd(1'b0, RD_BASE, 8'd2, ok, acc);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.txn_rdy === 1'b0) seen = 1'b1;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.txn_req, bus.txn_wr, rd_valid, done, busy, err, wr_ready} !== 7'b0 ||
        {bus.txn_raddr, bus.txn_waddr, bus.txn_wdata, rd_data} !== 128'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%h exp=0",
        {bus.txn_req, bus.txn_wr, rd_valid, done, busy, err, wr_ready}, rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_hold got=%b%b exp=00", cmd_ready, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || bus.txn_rdy !== 1'b1) begin
      failures++; $display("FAIL rstmid_ready got=%b exp=1", seen);
    end
    checks++;
    if (obs_rd.size() != rb) begin failures++; $display("FAIL rstmid_orphan got=%0d exp=0", obs_rd.size() - rb); end
    cfg_lat = 3;
    d0 = done_cnt;
    issue_cmd(1'b0, RD_BASE + 32'h8, 8'd1, ok, acc);
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || obs_rd.size() != rb + 1 || obs_rd[rb] !== rom(RD_BASE + 32'h8)) begin
      failures++; $display("FAIL rstmid_next got=%0d words exp=1 word %h", obs_rd.size() - rb, rom(RD_BASE + 32'h8));
    end
  endtask

  task automatic test_wrap_ignore_busy();
    logic [31:0] exp_rd [$];
    logic [63:0] exp_a [$];
    logic [31:0] e;
    logic [63:0] ea;
    bit ok;
    int acc, d0, e0, rb, ab;
    cfg_never = 1'b0; cfg_ack = 2; cfg_lat = 3;
    d0 = done_cnt; e0 = edge_cnt; rb = obs_rd.size(); ab = obs_addr.size();
    exp_rd.push_back(rom(32'hFFFF_FFFC)); exp_a.push_back({32'hFFFF_FFFC, 32'h0});
    exp_rd.push_back(rom(32'h0000_0000)); exp_a.push_back({32'h0000_0000, 32'h0});
    issue_cmd(1'b0, 32'hFFFF_FFFC, 8'd2, ok, acc);
    cmd_wr = 1'b1; cmd_addr = WR_BASE; cmd_len = 8'd5; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || edge_cnt - e0 != 2) begin
      failures++; $display("FAIL wrap_done_edges got=%0d/%0d exp=1/2", done_cnt - d0, edge_cnt - e0);
    end
    for (int i = 0; exp_a.size() > 0; i++) begin
      ea = exp_a.pop_front();
      e  = exp_rd.pop_front();
      checks++;
      if (ab + i >= obs_addr.size() || rb + i >= obs_rd.size()) begin
        failures++; $display("FAIL wrap_word[%0d] got=none exp=%h/%h", i, ea, e);
      end else if (obs_addr[ab + i] !== ea || obs_rd[rb + i] !== e) begin
        failures++; $display("FAIL wrap_word[%0d] got=%h/%h exp=%h/%h", i, obs_addr[ab + i], obs_rd[rb + i], ea, e);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_len0();
    test_timeout();
    test_reset_mid();
    test_wrap_ignore_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
